shift_pattern_serializer: RTL and testbench

//   Upstream stimulus stage for the 4-bit bidirectional shift register on Basys-3.

---
 rtl/shift_ser_pkg.sv | 15 +
 rtl/shift_pattern_serializer_if.sv | 23 ++
 rtl/button_debouncer.sv | 35 +++
 rtl/shift_pattern_serializer.sv | 124 ++++++++++++
 tb/tb_shift_pattern_serializer.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/shift_ser_pkg.sv
// Shared types for the shift-register pattern serializer.
package shift_ser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Shift direction as seen by the downstream register.
  localparam logic DIR_UP   = 1'b0;  // data enters q[0], MSB sent first
  localparam logic DIR_DOWN = 1'b1;  // data enters q[WIDTH-1], LSB sent first

endpackage

// File: rtl/shift_pattern_serializer_if.sv
// Switch/button inputs and serial outputs between the serializer and the board.
interface shift_pattern_serializer_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start_btn;
  logic [WIDTH-1:0] pattern_sw;
  logic             dir_sw;
  logic             data;
  logic             mode;
  logic             shift_tick;
  logic             busy;
  logic             done;

  modport master (
    input  start_btn, pattern_sw, dir_sw,
    output data, mode, shift_tick, busy, done
  );

  modport slave (
    output start_btn, pattern_sw, dir_sw,
    input  data, mode, shift_tick, busy, done
  );
endinterface

// File: rtl/button_debouncer.sv
// Two-flop synchronizer, stability counter and registered rising-edge pulse.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [1:0]       sync_q;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;
  logic             settle_c;

  // Level flips once the synchronized input has disagreed for the full window.
  assign settle_c = (sync_q[1] != level_q) &&
                    (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      pulse   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn};
      pulse  <= settle_c & sync_q[1];
      if (settle_c) level_q <= sync_q[1];
      if ((sync_q[1] == level_q) || settle_c) cnt_q <= '0;
      else                                    cnt_q <= cnt_q + CNT_W'(1);
    end
  end
endmodule

// File: rtl/shift_pattern_serializer.sv
// Captures a switch pattern on a debounced press and serializes it, one bit per shift tick.
module shift_pattern_serializer
  import shift_ser_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned TICK_DIV        = 75000000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input logic                        clk,
  input logic                        clear,
  shift_pattern_serializer_if.master bus
);
  localparam int unsigned TICK_W = $clog2(TICK_DIV);
  localparam int unsigned IDX_W  = $clog2(WIDTH + 1);

  state_t            state_q, state_d;
  logic [TICK_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0]  shadow_q, shadow_d;
  logic              mode_q, mode_d;
  logic              data_q, data_d;
  logic              tick_q, tick_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              start_pulse;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debouncer (
    .clk   (clk),
    .rst_n (clear),
    .btn   (bus.start_btn),
    .pulse (start_pulse)
  );

  // Bit number idx of the frame: MSB-first when shifting up, LSB-first when shifting down.
  function automatic logic pick_bit(input logic [WIDTH-1:0] pat, input logic dir,
                                    input logic [IDX_W-1:0] idx);
    logic [WIDTH-1:0] lsb_first;
    logic [WIDTH-1:0] msb_first;
    lsb_first = pat >> idx;
    msb_first = pat << idx;
    return (dir == DIR_DOWN) ? lsb_first[0] : msb_first[WIDTH-1];
  endfunction

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      mode_q   <= 1'b0;
      data_q   <= 1'b0;
      tick_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      mode_q   <= mode_d;
      data_q   <= data_d;
      tick_q   <= tick_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Outputs are computed one cycle ahead so every port comes straight from a flop.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    mode_d   = mode_q;
    data_d   = data_q;
    tick_d   = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_pulse) begin
          state_d = LOAD;
          busy_d  = 1'b1;
        end
      end
      LOAD: begin
        shadow_d = bus.pattern_sw;
        mode_d   = bus.dir_sw;
        cnt_d    = '0;
        idx_d    = '0;
        data_d   = pick_bit(bus.pattern_sw, bus.dir_sw, '0);
        state_d  = SHIFT;
      end
      SHIFT: begin
        if (cnt_q == TICK_W'(TICK_DIV - 1)) begin
          cnt_d = '0;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(WIDTH - 1)) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            data_d  = 1'b0;
          end else begin
            data_d = pick_bit(shadow_q, mode_q, idx_q + IDX_W'(1));
          end
        end else begin
          cnt_d  = cnt_q + TICK_W'(1);
          tick_d = (cnt_q == TICK_W'(TICK_DIV - 2));
        end
      end
      DONE: begin
        state_d = IDLE;
        data_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.data       = data_q;
  assign bus.mode       = mode_q;
  assign bus.shift_tick = tick_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_shift_pattern_serializer.sv
// Randomized frame-level bench for shift_pattern_serializer with a downstream register model.
module tb_shift_pattern_serializer;
  localparam int unsigned W  = 4;
  localparam int unsigned TD = 4;
  localparam int unsigned DB = 3;

  logic clk = 1'b0;
  logic clear;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  shift_pattern_serializer_if #(.WIDTH(W)) sif ();

  shift_pattern_serializer #(
    .WIDTH(W), .TICK_DIV(TD), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (sif.master)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit bounce);
    if (bounce) begin
      for (int i = 0; i < 10; i++) begin
        sif.start_btn = (i % 2 == 0);
        @(negedge clk);
      end
    end
    sif.start_btn = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_data"}, sif.data, 0);
    check_eq({tag, "_mode"}, sif.mode, 0);
    check_eq({tag, "_tick"}, sif.shift_tick, 0);
    check_eq({tag, "_busy"}, sif.busy, 0);
    check_eq({tag, "_done"}, sif.done, 0);
  endtask

  // Follows one frame from LOAD; abort_at > 0 pulses clear after that cycle.
  task automatic run_frame(input logic [W-1:0] pat, input bit dir, input bit disturb,
                           input int abort_at);
    int           waited = 0;
    logic [W-1:0] q      = '0;
    int           bit_no;
    logic         exp_bit;
    while (sif.busy !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check_eq("load_seen", sif.busy, 1);
    if (sif.busy !== 1'b1) return;
    for (int off = 1; off <= int'(W * TD); off++) begin
      @(negedge clk);
      bit_no  = (off - 1) / int'(TD);
      exp_bit = dir ? pat[bit_no] : pat[int'(W) - 1 - bit_no];
      check_eq($sformatf("tick@%0d", off), sif.shift_tick, (off % int'(TD) == 0));
      check_eq($sformatf("busy@%0d", off), sif.busy, 1);
      check_eq($sformatf("mode@%0d", off), sif.mode, dir);
      check_eq($sformatf("data@%0d", off), sif.data, exp_bit);
      if (sif.shift_tick === 1'b1) q = dir ? {sif.data, q[W-1:1]} : {q[W-2:0], sif.data};
      if (disturb) begin
        if (off == 3) sif.start_btn = 1'b0;
        if (off == 5) begin
          sif.pattern_sw = ~pat;
          sif.dir_sw     = ~dir;
        end
        if (off == 8) sif.start_btn = 1'b1;
      end
      if (abort_at == off) begin
        #2 clear = 1'b0;
        #1 check_all_zero("abort");
        @(negedge clk);
        sif.start_btn = 1'b0;
        clear = 1'b1;
        return;
      end
    end
    @(negedge clk);
    check_eq("done_pulse", sif.done, 1);
    check_eq("done_busy", sif.busy, 0);
    check_eq("done_data", sif.data, 0);
    check_eq("done_tick", sif.shift_tick, 0);
    check_eq("done_mode", sif.mode, dir);
    check_eq("q_final", q, pat);
    @(negedge clk);
    check_eq("idle_done", sif.done, 0);
    check_eq("idle_busy", sif.busy, 0);
  endtask

  task automatic release_and_settle();
    sif.start_btn = 1'b0;
    idle(12);
    check_eq("no_restart", sif.busy, 0);
  endtask

  task automatic frame(input logic [W-1:0] pat, input bit dir, input bit bounce, input bit disturb);
    sif.pattern_sw = pat;
    sif.dir_sw     = dir;
    press(bounce);
    run_frame(pat, dir, disturb, 0);
    release_and_settle();
  endtask

  initial begin
    logic [W-1:0] pat;
    bit           dir;
    clear          = 1'b1;
    sif.start_btn  = 1'b1;
    sif.pattern_sw = '0;
    sif.dir_sw     = 1'b0;
    #1 clear = 1'b0;
    idle(4);
    check_all_zero("reset");
    sif.start_btn = 1'b0;
    @(negedge clk);
    clear = 1'b1;
    idle(10);
    check_all_zero("post_reset");

    frame(4'b1011, 1'b0, 1'b1, 1'b0);
    frame(4'b0110, 1'b1, 1'b0, 1'b0);
    frame(4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b1);

    pat = 4'($urandom_range(0, 15));
    sif.pattern_sw = pat;
    sif.dir_sw     = 1'b1;
    press(1'b0);
    run_frame(pat, 1'b1, 1'b0, 2 * int'(TD) + 1);
    idle(8);
    check_eq("abort_no_done", sif.done, 0);
    check_eq("abort_idle", sif.busy, 0);
    frame(4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 6; n++) begin
      pat = 4'($urandom_range(0, 15));
      dir = 1'($urandom_range(0, 1));
      frame(pat, dir, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
